// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, source indices and the writeback request payload for the
// register-bank writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned AMOUNT     = 16;
    localparam int unsigned ADDRESSLEN = 4;

    localparam int unsigned SRC_ALU  = 0;
    localparam int unsigned SRC_LOAD = 1;

    typedef struct packed {
        logic [ADDRESSLEN-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_slot.sv
// Single-entry writeback holding slot: full flag, payload and a "younger than
// the other slot" age bit.
module wb_slot #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDRESSLEN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [ADDRESSLEN-1:0] in_rd,
    input  logic [XLEN-1:0]       in_data,
    input  logic                  other_full,
    input  logic                  other_grant,
    output logic                  full,
    output logic                  young,
    output logic [ADDRESSLEN-1:0] rd,
    output logic [XLEN-1:0]       data
);

    logic                  full_q, full_d;
    logic                  young_q, young_d;
    logic [ADDRESSLEN-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;

    // Younger only if the other slot keeps an older entry across this edge.
    always_comb begin
        full_d  = full_q;
        young_d = young_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (load) begin
            full_d  = 1'b1;
            young_d = other_full & ~other_grant;
            rd_d    = in_rd;
            data_d  = in_data;
        end else begin
            if (clear) begin
                full_d  = 1'b0;
                young_d = 1'b0;
            end
            if (other_grant) begin
                young_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            young_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            young_q <= young_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign full  = full_q;
    assign young = young_q;
    assign rd    = rd_q;
    assign data  = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register bank's single write port between the ALU and load
// writeback sources, oldest slot first, and exports the pending-write bitmap.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN       = regfile_wb_arbiter_pkg::XLEN,
    parameter int unsigned AMOUNT     = regfile_wb_arbiter_pkg::AMOUNT,
    parameter int unsigned ADDRESSLEN = regfile_wb_arbiter_pkg::ADDRESSLEN,
    parameter int unsigned ZERO_DROP  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [ADDRESSLEN-1:0] req_rd0,
    input  logic [XLEN-1:0]       req_data0,
    input  logic [ADDRESSLEN-1:0] req_rd1,
    input  logic [XLEN-1:0]       req_data1,
    output logic [1:0]            req_ready,
    output logic                  wb_en,
    output logic [ADDRESSLEN-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic [AMOUNT-1:0]     pending
);

    logic [1:0]            full, young, grant_c, load_c, drop_c;
    logic [ADDRESSLEN-1:0] slot_rd [2];
    logic [XLEN-1:0]       slot_data [2];
    logic [ADDRESSLEN-1:0] in_rd [2];
    logic [XLEN-1:0]       in_data [2];

    logic                  rr_q, rr_d;
    logic                  wb_en_q, wb_en_d;
    logic [ADDRESSLEN-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic [AMOUNT-1:0]     pending_c;

    assign in_rd[SRC_ALU]    = req_rd0;
    assign in_rd[SRC_LOAD]   = req_rd1;
    assign in_data[SRC_ALU]  = req_data0;
    assign in_data[SRC_LOAD] = req_data1;

    // Age first, then same-rd keeps the ALU ahead of the load, then round robin.
    always_comb begin
        grant_c = 2'b00;
        rr_d    = rr_q;
        case (full)
            2'b01: grant_c = 2'b01;
            2'b10: grant_c = 2'b10;
            2'b11: begin
                if (young[0] != young[1]) begin
                    grant_c = young[0] ? 2'b10 : 2'b01;
                end else if (slot_rd[0] == slot_rd[1]) begin
                    grant_c = 2'b01;
                end else begin
                    grant_c = rr_q ? 2'b10 : 2'b01;
                    rr_d    = ~rr_q;
                end
            end
            default: grant_c = 2'b00;
        endcase
    end

    assign req_ready = reset ? 2'b00 : (~full | grant_c);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            drop_c[i] = (ZERO_DROP != 0) && (in_rd[i] == '0);
            load_c[i] = req_valid[i] & req_ready[i] & ~drop_c[i];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_slot
        wb_slot #(
            .XLEN       (XLEN),
            .ADDRESSLEN (ADDRESSLEN)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .load        (load_c[g]),
            .clear       (grant_c[g]),
            .in_rd       (in_rd[g]),
            .in_data     (in_data[g]),
            .other_full  (full[1-g]),
            .other_grant (grant_c[1-g]),
            .full        (full[g]),
            .young       (young[g]),
            .rd          (slot_rd[g]),
            .data        (slot_data[g])
        );
    end

    always_comb begin
        wb_en_d   = |grant_c;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (grant_c[1]) begin
            wb_rd_d   = slot_rd[1];
            wb_data_d = slot_data[1];
        end else if (grant_c[0]) begin
            wb_rd_d   = slot_rd[0];
            wb_data_d = slot_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q      <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Every register with a write still in flight, for decode RAW stalls.
    always_comb begin
        pending_c = '0;
        for (int unsigned r = 0; r < AMOUNT; r++) begin
            if ((full[0] && slot_rd[0] == ADDRESSLEN'(r)) ||
                (full[1] && slot_rd[1] == ADDRESSLEN'(r)) ||
                (wb_en_q && wb_rd_q == ADDRESSLEN'(r))) begin
                pending_c[r] = 1'b1;
            end
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
    assign pending = pending_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes expected
// writes, a negedge monitor pops and compares every wb_en cycle.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b11;
    logic [3:0]  req_rd0 = '0, req_rd1 = '0;
    logic [31:0] req_data0 = '0, req_data1 = '0;
    logic [1:0]  req_ready;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [15:0] pending;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    bit          mon_en = 1'b0;
    wb_req_t     exp_q[$];
    logic [31:0] bank [16];

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_rd0   (req_rd0),
        .req_data0 (req_data0),
        .req_rd1   (req_rd1),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every issued write must match the head of the scoreboard.
    always @(negedge clk) begin
        wb_req_t e;
        if (mon_en && wb_en !== 1'b0) begin
            n_writes++;
            bank[wb_rd] = wb_data;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got en=%b rd=%0d data=%h expected no write",
                         wb_en, wb_rd, wb_data);
            end else begin
                e = exp_q.pop_front();
                check("wb_rd", 64'(wb_rd), 64'(e.rd));
                check("wb_data", 64'(wb_data), 64'(e.data));
            end
        end
    end

    task automatic push_req(input logic [1:0] v, input logic [3:0] rd0, input logic [31:0] d0,
                            input logic [3:0] rd1, input logic [31:0] d1);
        @(negedge clk);
        req_valid = v;
        req_rd0   = rd0;
        req_data0 = d0;
        req_rd1   = rd1;
        req_data1 = d1;
        #1;
        check("req_ready", 64'(req_ready & v), 64'(v));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
    endtask

    task automatic expect_wr(input logic [3:0] rd, input logic [31:0] d);
        wb_req_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int          n;
        int          xfers;
        int          w0;
        logic [1:0]  rdy;
        logic [3:0]  r0, r1;
        logic [31:0] d0, d1;

        for (int i = 0; i < 16; i++) bank[i] = '0;

        // Reset held with both sources requesting.
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_ready", 64'(req_ready), 64'(0));
            check("reset_wb_en", 64'(wb_en), 64'(0));
            check("reset_pending", 64'(pending), 64'(0));
        end
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 2'b00;
        mon_en    = 1'b1;
        wait_cycles(3);
        check("post_reset_pending", 64'(pending), 64'(0));

        // Single source latency and pending window.
        push_req(2'b01, 4'd5, 32'hDEAD_BEEF, 4'd0, 32'h0);
        expect_wr(4'd5, 32'hDEAD_BEEF);
        check("pend_slot", 64'(pending), 64'h0020);
        wait_cycles(1);
        check("single_wb_en", 64'(wb_en), 64'(1));
        check("pend_wb", 64'(pending), 64'h0020);
        wait_cycles(1);
        check("single_wb_en_off", 64'(wb_en), 64'(0));
        check("pend_clear", 64'(pending), 64'(0));

        // Equal-age ties: rr starts at 0, then flips.
        push_req(2'b11, 4'd3, 32'h0000_0033, 4'd7, 32'h0000_0077);
        expect_wr(4'd3, 32'h0000_0033);
        expect_wr(4'd7, 32'h0000_0077);
        wait_cycles(3);
        push_req(2'b11, 4'd4, 32'h0000_0044, 4'd8, 32'h0000_0088);
        expect_wr(4'd8, 32'h0000_0088);
        expect_wr(4'd4, 32'h0000_0044);
        wait_cycles(3);

        // Same rd, equal age: ALU first, load last.
        push_req(2'b11, 4'd9, 32'd1, 4'd9, 32'd2);
        expect_wr(4'd9, 32'd1);
        expect_wr(4'd9, 32'd2);
        wait_cycles(3);
        check("bank_rd9", 64'(bank[9]), 64'(2));
        check("drained_before_stream", 64'(exp_q.size()), 64'(0));

        // Reset to return rr to 0 before streaming.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Streaming with both sources always valid.
        n     = 0;
        xfers = 0;
        r0 = 4'((n % 15) + 1); d0 = 32'hA500_0000 + 32'(n); n++;
        r1 = 4'((n % 15) + 1); d1 = 32'hA500_0000 + 32'(n); n++;
        w0 = n_writes;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_valid = 2'b11;
            req_rd0   = r0;
            req_data0 = d0;
            req_rd1   = r1;
            req_data1 = d1;
            #1;
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy[0]) begin
                expect_wr(r0, d0);
                xfers++;
                r0 = 4'((n % 15) + 1); d0 = 32'hA500_0000 + 32'(n); n++;
            end
            if (rdy[1]) begin
                expect_wr(r1, d1);
                xfers++;
                r1 = 4'((n % 15) + 1); d1 = 32'hA500_0000 + 32'(n); n++;
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("stream_xfers", 64'(xfers), 64'(21));
        check("stream_writes", 64'(n_writes - w0), 64'(21));
        check("stream_drained", 64'(exp_q.size()), 64'(0));

        // Zero-register write is accepted and dropped.
        push_req(2'b01, 4'd0, 32'h0000_1234, 4'd0, 32'h0);
        check("zero_pending", 64'(pending), 64'(0));
        wait_cycles(3);
        check("zero_no_wb", 64'(wb_en), 64'(0));

        // Both slots filled, then reset before either issues.
        push_req(2'b11, 4'd11, 32'h0000_0B0B, 4'd12, 32'h0000_0C0C);
        check("fill_pending", 64'(pending), 64'h1800);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(4);
        check("midreset_pending", 64'(pending), 64'(0));
        check("midreset_wb_en", 64'(wb_en), 64'(0));
        check("final_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
